write_buffered: RTL and testbench

- Parametrised successor to the pipeline write-back stage.
- Commits register results, register-pair (upper) results, flag updates and PC redirects to the architectural register file.
- Stores go into a DEPTH-entry posted store buffer instead of stalling the pipeline for each memory acknowledge.
- Sits after execute; provides same-cycle feedback (forwarding) to earlier stages, and a store-buffer-empty indication used by memory ordering (fence).

---
 rtl/write_buffered.sv | 142 ++++++++++++++
 tb/tb_write_buffered.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffered.sv
// Write-back stage with a posted store buffer: commits register, pair, flag and PC
// updates, queues stores for memory, and provides same-cycle forwarding.
module write_buffered #(
  parameter int W         = 32,
  parameter int NR        = 32,
  parameter int PC_IDX    = NR - 1,
  parameter int FLAGS_IDX = NR - 2,
  parameter int FLAG_W    = 4,
  parameter int DEPTH     = 4,
  localparam int RI       = $clog2(NR),
  localparam int PW       = $clog2(DEPTH),
  localparam int CW       = PW + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [RI-1:0]     in_target,
  input  logic [W-1:0]      in_value,
  input  logic [W-1:0]      in_upper_value,
  input  logic              in_has_upper,
  input  logic              in_is_store,
  input  logic              in_fence,
  input  logic [W-1:0]      in_adjust,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [W-1:0]      in_pc,
  input  logic              in_has_flushed,
  input  logic [W-1:0]      next_pc,
  input  logic [NR*W-1:0]   regs_in,
  output logic [NR*W-1:0]   regs_out,
  output logic              hold,
  output logic              has_flushed,
  output logic              mem_req,
  output logic [W-1:0]      mem_addr,
  output logic [W-1:0]      mem_data,
  input  logic              mem_ack,
  output logic              fb_valid,
  output logic [RI-1:0]     fb_index,
  output logic [W-1:0]      fb_value,
  output logic [W-1:0]      fb_upper_value,
  output logic              fb_has_upper,
  output logic [CW-1:0]     sb_count,
  output logic              sb_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [NR*W-1:0] regs_q, regs_d;
  logic            has_flushed_q, has_flushed_d;
  logic [W-1:0]    sb_addr_q [DEPTH];
  logic [W-1:0]    sb_data_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            empty, full, pop, push, accept;
  logic [W-1:0]    base, st_addr;
  logic [RI:0]     upper_idx;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign pop    = mem_req && mem_ack;
  // A pop in the same cycle frees the slot the incoming store needs.
  assign hold   = reset_n && in_valid &&
                  ((in_is_store && full && !pop) || (in_fence && !empty));
  assign accept = in_valid && !hold;
  assign push   = accept && in_is_store;

  always_comb begin
    base = '0;
    if (in_target == RI'(PC_IDX))
      base = in_pc;
    else if (in_target != '0)
      base = regs_in[int'(in_target)*W +: W];
    st_addr = base + in_adjust;
  end

  always_comb begin
    regs_d    = regs_in;
    upper_idx = {1'b0, in_target} + (RI+1)'(1);
    if (accept && !in_is_store) begin
      if (in_target != '0 && in_target != RI'(PC_IDX))
        regs_d[int'(in_target)*W +: W] = in_value;
      if (in_has_upper && upper_idx < (RI+1)'(NR) &&
          upper_idx != (RI+1)'(PC_IDX) && upper_idx != (RI+1)'(FLAGS_IDX))
        regs_d[int'(upper_idx)*W +: W] = in_upper_value;
    end
    // A full write of the flags register takes priority over the field update.
    if (accept && (in_is_store || in_target != RI'(FLAGS_IDX)))
      regs_d[FLAGS_IDX*W + W-2 -: FLAG_W] = in_flags;
    if (hold)
      regs_d[PC_IDX*W +: W] = regs_q[PC_IDX*W +: W];
    else if (accept && !in_is_store && in_target == RI'(PC_IDX))
      regs_d[PC_IDX*W +: W] = in_value;
    else
      regs_d[PC_IDX*W +: W] = next_pc;
    regs_d[W-1:0] = '0;
  end

  always_comb begin
    has_flushed_d = accept ? in_has_flushed : 1'b0;
    rd_ptr_d      = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d      = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      regs_q        <= '0;
      has_flushed_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      regs_q        <= regs_d;
      has_flushed_q <= has_flushed_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push) begin
      sb_addr_q[wr_ptr_q] <= st_addr;
      sb_data_q[wr_ptr_q] <= in_value;
    end
  end

  assign regs_out       = regs_q;
  assign has_flushed    = has_flushed_q;
  assign mem_req        = !empty;
  assign mem_addr       = sb_addr_q[rd_ptr_q];
  assign mem_data       = sb_data_q[rd_ptr_q];
  assign sb_count       = count_q;
  assign sb_empty       = empty;
  assign fb_valid       = in_valid && !in_is_store && !hold;
  assign fb_index       = in_target;
  assign fb_value       = in_value;
  assign fb_upper_value = in_upper_value;
  assign fb_has_upper   = in_has_upper;

endmodule

// File: tb/tb_write_buffered.sv
// Bench for write_buffered: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the write-back stage.
module tb_write_buffered;
  localparam int W = 32, NR = 32, FLAG_W = 4, DEPTH = 4;
  localparam int PCI = NR - 1, FLI = NR - 2;
  localparam int RI = $clog2(NR), CW = $clog2(DEPTH) + 1;

  logic clock, reset_n, in_valid, in_has_upper, in_is_store, in_fence, in_has_flushed, mem_ack;
  logic [RI-1:0] in_target, fb_index;
  logic [W-1:0] in_value, in_upper_value, in_adjust, in_pc, next_pc;
  logic [FLAG_W-1:0] in_flags;
  logic [NR*W-1:0] regs_in, regs_out;
  logic hold, has_flushed, mem_req, fb_valid, fb_has_upper, sb_empty;
  logic [W-1:0] mem_addr, mem_data, fb_value, fb_upper_value;
  logic [CW-1:0] sb_count;

  write_buffered #(.W(W), .NR(NR), .PC_IDX(PCI), .FLAGS_IDX(FLI), .FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_target(in_target),
    .in_value(in_value), .in_upper_value(in_upper_value), .in_has_upper(in_has_upper),
    .in_is_store(in_is_store), .in_fence(in_fence), .in_adjust(in_adjust), .in_flags(in_flags),
    .in_pc(in_pc), .in_has_flushed(in_has_flushed), .next_pc(next_pc), .regs_in(regs_in),
    .regs_out(regs_out), .hold(hold), .has_flushed(has_flushed), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack), .fb_valid(fb_valid),
    .fb_index(fb_index), .fb_value(fb_value), .fb_upper_value(fb_upper_value),
    .fb_has_upper(fb_has_upper), .sb_count(sb_count), .sb_empty(sb_empty));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [W-1:0] ri [NR];
  logic [W-1:0] ro [NR];
  always_comb for (int i = 0; i < NR; i++) regs_in[i*W +: W] = ri[i];
  always_comb for (int i = 0; i < NR; i++) ro[i] = regs_out[i*W +: W];

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: expected register file, pending stores in order, flush marker.
  typedef struct packed { logic [W-1:0] addr; logic [W-1:0] data; } sb_t;
  sb_t m_q[$];
  logic [W-1:0] m_regs [NR];
  logic m_flushed;
  logic e_pop, e_hold, e_acc, e_fbv, e_req;
  logic [W-1:0] e_addr;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_q.delete();
    m_flushed = 1'b0;
  endtask

  task automatic model_comb();
    int cnt;
    logic [W-1:0] b;
    cnt    = m_q.size();
    e_req  = (cnt != 0);
    e_pop  = e_req && mem_ack;
    e_hold = in_valid && ((in_is_store && cnt == DEPTH && !e_pop) || (in_fence && cnt != 0));
    e_acc  = in_valid && !e_hold;
    e_fbv  = in_valid && !in_is_store && !e_hold;
    if (int'(in_target) == 0) b = '0;
    else if (int'(in_target) == PCI) b = in_pc;
    else b = ri[in_target];
    e_addr = b + in_adjust;
  endtask

  task automatic model_edge();
    logic [W-1:0] nr [NR];
    int t, u;
    model_comb();
    nr = ri;
    t = int'(in_target);
    u = t + 1;
    if (e_acc && !in_is_store) begin
      if (t != 0 && t != PCI) nr[t] = in_value;
      if (in_has_upper && u < NR && u != PCI && u != FLI) nr[u] = in_upper_value;
    end
    if (e_acc && !(!in_is_store && t == FLI)) nr[FLI][W-2 -: FLAG_W] = in_flags;
    if (e_hold) nr[PCI] = m_regs[PCI];
    else if (e_acc && !in_is_store && t == PCI) nr[PCI] = in_value;
    else nr[PCI] = next_pc;
    nr[0] = '0;
    m_regs = nr;
    if (e_pop) void'(m_q.pop_front());
    if (e_acc && in_is_store) m_q.push_back('{addr: e_addr, data: in_value});
    m_flushed = e_acc ? in_has_flushed : 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    ri = m_regs;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_target = '0; in_value = '0; in_upper_value = '0; in_has_upper = 0;
    in_is_store = 0; in_fence = 0; in_adjust = '0; in_flags = '0; in_pc = '0;
    in_has_flushed = 0; next_pc = '0; mem_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    for (int i = 0; i < NR; i++) ri[i] = '0;
    model_reset();
    @(posedge clock); #1;
    n_checks++; if (regs_out !== '0) begin n_fail++; $display("FAIL reset_regs: got %h want 0", regs_out); end
    n_checks++; if (sb_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sb_count); end
    n_checks++; if (sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", sb_empty); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_memreq: got %b want 0", mem_req); end
    n_checks++; if (has_flushed !== 1'b0) begin n_fail++; $display("FAIL reset_flushed: got %b want 0", has_flushed); end
    reset_n = 1;
  endtask

  task automatic test_reg_write();
    in_valid = 1; in_target = RI'(5); in_value = 32'h1234; in_flags = 4'h5; next_pc = 32'h100;
    #1;
    n_checks++; if (fb_valid !== 1'b1) begin n_fail++; $display("FAIL wr_fbvalid: got %b want 1", fb_valid); end
    n_checks++; if (fb_index !== RI'(5)) begin n_fail++; $display("FAIL wr_fbindex: got %0d want 5", fb_index); end
    n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL wr_hold: got %b want 0", hold); end
    tick();
    n_checks++; if (ro[5] !== 32'h1234) begin n_fail++; $display("FAIL wr_r5: got %h want 1234", ro[5]); end
    n_checks++; if (ro[PCI] !== 32'h100) begin n_fail++; $display("FAIL wr_pc: got %h want 100", ro[PCI]); end
    n_checks++; if (ro[FLI] !== 32'h2800_0000) begin n_fail++; $display("FAIL wr_flags: got %h want 28000000", ro[FLI]); end
  endtask

  task automatic test_pair();
    in_valid = 1; in_target = RI'(6); in_value = 32'hA; in_upper_value = 32'hB; in_has_upper = 1;
    in_flags = 4'h0; next_pc = 32'h104;
    tick();
    n_checks++; if (ro[6] !== 32'hA) begin n_fail++; $display("FAIL pair_r6: got %h want a", ro[6]); end
    n_checks++; if (ro[7] !== 32'hB) begin n_fail++; $display("FAIL pair_r7: got %h want b", ro[7]); end
    in_target = RI'(FLI - 1); in_value = 32'h11; in_upper_value = 32'h22; in_flags = 4'hF;
    tick();
    n_checks++; if (ro[FLI-1] !== 32'h11) begin n_fail++; $display("FAIL pair_lo: got %h want 11", ro[FLI-1]); end
    n_checks++; if (ro[FLI] !== 32'h7800_0000) begin n_fail++; $display("FAIL pair_flags: got %h want 78000000", ro[FLI]); end
    in_has_upper = 0; in_flags = 4'h0;
  endtask

  task automatic test_store_full();
    logic [W-1:0] saved_pc;
    mem_ack = 0; in_valid = 1; in_is_store = 1; in_target = RI'(3); ri[3] = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      in_adjust = W'(i * 4); in_value = W'(32'hD0 + i);
      #1;
      n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL st_hold%0d: got %b want 0", i, hold); end
      tick();
    end
    n_checks++; if (sb_count !== CW'(4)) begin n_fail++; $display("FAIL st_count4: got %0d want 4", sb_count); end
    n_checks++; if (mem_addr !== 32'h1000 || mem_data !== 32'hD0) begin n_fail++; $display("FAIL st_head: got %h/%h want 1000/d0", mem_addr, mem_data); end
    in_adjust = 32'h10; in_value = 32'hD4; saved_pc = ro[PCI]; next_pc = 32'hBEEF;
    #1;
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL st_fullhold: got %b want 1", hold); end
    tick();
    n_checks++; if (ro[PCI] !== saved_pc) begin n_fail++; $display("FAIL st_pcfrozen: got %h want %h", ro[PCI], saved_pc); end
    mem_ack = 1;
    #1;
    n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL st_pophold: got %b want 0", hold); end
    tick();
    n_checks++; if (sb_count !== CW'(4)) begin n_fail++; $display("FAIL st_countkeep: got %0d want 4", sb_count); end
    in_valid = 0; in_is_store = 0;
    for (int j = 1; j <= 4; j++) begin
      #1;
      n_checks++;
      if (mem_addr !== W'(32'h1000 + 4*j) || mem_data !== W'(32'hD0 + j)) begin
        n_fail++; $display("FAIL st_order%0d: got %h/%h want %h/%h", j, mem_addr, mem_data, 32'h1000 + 4*j, 32'hD0 + j);
      end
      tick();
    end
    n_checks++; if (sb_empty !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL st_drained: got empty=%b req=%b want 1/0", sb_empty, mem_req); end
    mem_ack = 0;
  endtask

  task automatic test_addr_wrap();
    in_valid = 1; in_is_store = 1; mem_ack = 0;
    ri[3] = 32'hFFFF_FFF0; in_target = RI'(3); in_adjust = 32'h20; in_value = 32'h1;
    tick();
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL wrap_addr: got %h want 10", mem_addr); end
    in_target = '0; in_adjust = 32'h55; in_value = 32'h2;
    tick();
    in_target = RI'(PCI); in_pc = 32'h2000; in_adjust = 32'h8; in_value = 32'h3;
    tick();
    in_valid = 0; in_is_store = 0; mem_ack = 1;
    tick();
    n_checks++; if (mem_addr !== 32'h55 || mem_data !== 32'h2) begin n_fail++; $display("FAIL zero_base: got %h/%h want 55/2", mem_addr, mem_data); end
    tick();
    n_checks++; if (mem_addr !== 32'h2008 || mem_data !== 32'h3) begin n_fail++; $display("FAIL pc_base: got %h/%h want 2008/3", mem_addr, mem_data); end
    tick();
    mem_ack = 0;
  endtask

  task automatic test_fence();
    logic [W-1:0] saved_pc;
    in_valid = 1; in_is_store = 1; in_target = '0; mem_ack = 0;
    in_adjust = 32'h100; in_value = 32'h5; tick();
    in_adjust = 32'h104; in_value = 32'h6; tick();
    in_is_store = 0; in_fence = 1; in_target = RI'(9); in_value = 32'h99;
    saved_pc = ro[PCI]; next_pc = 32'h3333;
    #1;
    n_checks++; if (hold !== 1'b1 || fb_valid !== 1'b0) begin n_fail++; $display("FAIL fence_hold: got hold=%b fb=%b want 1/0", hold, fb_valid); end
    tick();
    n_checks++; if (ro[PCI] !== saved_pc) begin n_fail++; $display("FAIL fence_pc: got %h want %h", ro[PCI], saved_pc); end
    mem_ack = 1;
    #1;
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL fence_hold2: got %b want 1", hold); end
    tick();
    #1;
    n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL fence_hold1: got %b want 1", hold); end
    tick();
    #1;
    n_checks++; if (hold !== 1'b0 || fb_valid !== 1'b1) begin n_fail++; $display("FAIL fence_release: got hold=%b fb=%b want 0/1", hold, fb_valid); end
    tick();
    n_checks++; if (ro[9] !== 32'h99 || ro[PCI] !== 32'h3333) begin n_fail++; $display("FAIL fence_retire: got r9=%h pc=%h want 99/3333", ro[9], ro[PCI]); end
    in_fence = 0; mem_ack = 0;
  endtask

  task automatic test_pc_and_reset();
    in_valid = 1; in_is_store = 0; in_target = RI'(PCI); in_value = 32'h400; next_pc = 32'h999;
    tick();
    n_checks++; if (ro[PCI] !== 32'h400) begin n_fail++; $display("FAIL pc_write: got %h want 400", ro[PCI]); end
    in_is_store = 1; in_target = RI'(2); mem_ack = 0;
    for (int i = 0; i < 3; i++) begin in_adjust = W'(i); in_value = W'(i); tick(); end
    in_valid = 0; in_is_store = 0;
    #1;
    n_checks++; if (sb_count !== CW'(3)) begin n_fail++; $display("FAIL midrst_pending: got %0d want 3", sb_count); end
    reset_n = 0;
    #1;
    n_checks++; if (sb_empty !== 1'b1 || mem_req !== 1'b0 || sb_count !== '0) begin n_fail++; $display("FAIL midrst_clear: got empty=%b req=%b cnt=%0d want 1/0/0", sb_empty, mem_req, sb_count); end
    n_checks++; if (regs_out !== '0) begin n_fail++; $display("FAIL midrst_regs: got %h want 0", regs_out); end
    model_reset();
    for (int i = 0; i < NR; i++) ri[i] = '0;
    @(posedge clock); #1;
    reset_n = 1;
  endtask

  task automatic test_random();
    logic [NR*W-1:0] exp_regs;
    for (int c = 0; c < 400; c++) begin
      in_valid       = ($urandom_range(0, 9) < 8);
      in_is_store    = ($urandom_range(0, 99) < 35);
      in_fence       = ($urandom_range(0, 9) == 0);
      in_has_upper   = $urandom_range(0, 1) == 1;
      in_target      = ($urandom_range(0, 3) == 0) ? RI'($urandom_range(FLI - 1, NR - 1)) : RI'($urandom_range(0, NR - 1));
      in_value       = $urandom;
      in_upper_value = $urandom;
      in_adjust      = $urandom;
      in_flags       = FLAG_W'($urandom);
      in_pc          = $urandom;
      next_pc        = $urandom;
      in_has_flushed = $urandom_range(0, 1) == 1;
      mem_ack        = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) == 0) ri[$urandom_range(0, NR - 1)] = $urandom;
      model_comb();
      #1;
      n_checks++; if (hold !== e_hold) begin n_fail++; $display("FAIL rnd_hold c%0d: got %b want %b", c, hold, e_hold); end
      n_checks++; if (fb_valid !== e_fbv) begin n_fail++; $display("FAIL rnd_fbvalid c%0d: got %b want %b", c, fb_valid, e_fbv); end
      n_checks++; if (mem_req !== e_req) begin n_fail++; $display("FAIL rnd_memreq c%0d: got %b want %b", c, mem_req, e_req); end
      n_checks++; if (sb_count !== CW'(m_q.size())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, sb_count, m_q.size()); end
      if (e_req) begin
        n_checks++;
        if (mem_addr !== m_q[0].addr || mem_data !== m_q[0].data) begin
          n_fail++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", c, mem_addr, mem_data, m_q[0].addr, m_q[0].data);
        end
      end
      tick();
      for (int i = 0; i < NR; i++) exp_regs[i*W +: W] = m_regs[i];
      n_checks++; if (regs_out !== exp_regs) begin n_fail++; $display("FAIL rnd_regs c%0d: mismatch in register file", c); end
      n_checks++; if (has_flushed !== m_flushed) begin n_fail++; $display("FAIL rnd_flushed c%0d: got %b want %b", c, has_flushed, m_flushed); end
      n_checks++; if (sb_empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c%0d: got %b want %b", c, sb_empty, m_q.size() == 0); end
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_pair();
    test_store_full();
    test_addr_wrap();
    test_fence();
    test_pc_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
